async_fifo_reader: RTL

- Read-side consumer for the async FIFO. Lives entirely in the read clock domain.
- Drains words using the FIFO's rd_empty and data_out, with a fixed 1-cycle read latency.
- Presents the words on a valid/ready stream to downstream logic through a 2-entry buffer.
- Counts received words and checks that the data pattern is an incrementing sequence, which is the FIFO's built-in test pattern.

---
 rtl/async_fifo_reader_pkg.sv | 10 +
 rtl/async_fifo_reader_seq_checker.sv | 57 +++++
 rtl/async_fifo_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/async_fifo_reader_pkg.sv
// Shared constants for the async FIFO read side.
// Read latency, reader buffer depth and default widths.
package async_fifo_pkg;

  localparam int FIFO_RD_LATENCY  = 1;
  localparam int READER_BUF_DEPTH = 2;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CNT_WIDTH    = 16;

endpackage

// File: rtl/async_fifo_reader_seq_checker.sv
// Incrementing-sequence checker for captured FIFO words.
// First word after reset only seeds the expected value.
module seq_checker
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap_valid,
  input  logic [DATA_WIDTH-1:0] cap_data,
  output logic                  seq_err,
  output logic [CNT_WIDTH-1:0]  err_count
);

  logic                  first_seen_q, first_seen_d;
  logic [DATA_WIDTH-1:0] expect_q, expect_d;
  logic                  seq_err_q, seq_err_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;

  always_comb begin
    first_seen_d = first_seen_q;
    expect_d     = expect_q;
    seq_err_d    = seq_err_q;
    err_count_d  = err_count_q;
    if (cap_valid) begin
      first_seen_d = 1'b1;
      // resync on every word so one gap costs one error
      expect_d     = cap_data + DATA_WIDTH'(1);
      if (first_seen_q && (cap_data != expect_q)) begin
        seq_err_d = 1'b1;
        if (err_count_q != '1) begin
          err_count_d = err_count_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_seen_q <= 1'b0;
      expect_q     <= '0;
      seq_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      first_seen_q <= first_seen_d;
      expect_q     <= expect_d;
      seq_err_q    <= seq_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/async_fifo_reader.sv
// Read-side consumer: drains the FIFO into a 2-entry
// valid/ready buffer, counts words and checks the sequence.
module async_fifo_reader
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter bit CHECK_SEQ  = 1'b1
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rd_empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  seq_err
);

  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic [2:0]            occ;
  logic                  push;
  logic                  pop;

  assign occ  = {1'b0, count_q} + {2'b00, inflight_q};
  assign push = inflight_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    rd_en = 1'b0;
    // reserve a slot for every read in flight
    if (!reset && enable && !rd_empty &&
        (occ < 3'(READER_BUF_DEPTH))) begin
      rd_en = 1'b1;
    end
  end

  always_comb begin
    inflight_d   = rd_en;
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    word_count_d = word_count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = data_out;
        else                 tail_d = data_out;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = data_out;
        end else begin
          head_d = tail_q;
          tail_d = data_out;
        end
      end
      default: ;
    endcase
    if (push && (word_count_q != '1)) begin
      word_count_d = word_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      word_count_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = (count_q != 2'd0);
  assign out_data   = head_q;
  assign word_count = word_count_q;

  if (CHECK_SEQ) begin : g_chk
    seq_checker #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_seq_checker (
      .clk       (rd_clk),
      .reset     (reset),
      .cap_valid (push),
      .cap_data  (data_out),
      .seq_err   (seq_err),
      .err_count (err_count)
    );
  end else begin : g_nochk
    assign seq_err   = 1'b0;
    assign err_count = '0;
  end

endmodule
